booth_group_enc: RTL and testbench
==================================

# booth_group_enc

Sequential radix-4 Booth recoder for the multiplier operand. It accepts one signed multiplier X per transaction and emits its W/2 overlapping 3-bit Booth groups, least-significant group first, one per handshake. The partial-product action decoder consumes each group together with the multiplicand and selects 0, ±Y or ±2Y. The block sits between the operand register stage and the partial-product generator / accumulator.

## Interface
- W, default 8: multiplier width in bits; even, ≥4.
- NG, default W/2 (derived, not overridable): number of groups per operand.
- IW, default $clog2(NG) (derived): group index width.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  X is valid.
- in_ready  out  1  block can accept X.
- x  in  W  signed multiplier (two's complement).
- out_valid  out  1  group fields are valid.
- out_ready  in  1  consumer accepts the current group.
- g  out  3  Booth group {x[2i+1], x[2i], x[2i-1]}, with x[-1]=0.
- idx  out  IW  group number i; weight is 4^i.
- last  out  1  high on group NG-1.
- neg  out  1  group selects a negative multiple (100, 101, 110).
- two  out  1  group selects magnitude 2 (011, 100).
- zero  out  1  group selects 0 (000, 111).

## Operation
- States: IDLE, EMIT.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_fire, load the shift register sr = {x, 1'b0} (W+1 bits, bit 0 is x[-1]), set idx=0, and go to EMIT.
- EMIT:
  - out_valid=1, g=sr[2:0], last=(idx==NG-1).
  - On out_fire with last=0: shift sr right by 2 with sign extension (arithmetic shift), then idx+1.
  - On out_fire with last=1:
    - If in_valid is also high, load the new x in the same cycle and stay in EMIT with idx=0 (zero-bubble back-to-back).
    - Otherwise go to IDLE.
- in_ready = (state==IDLE) | (out_fire & last). This is combinational from out_ready.
- neg/two/zero are decoded combinationally from g only:
  - zero = (g==000)|(g==111)
  - neg = g[2] & ~zero
  - two = (g==011)|(g==100)
- Signed identity: Σ d_i·4^i = x, where d_i ∈ {−2..+2} is the digit encoded by g_i.

## Timing
- Reset values (asynchronous, applied immediately):
  - state=IDLE, sr=0, idx=0.
  - out_valid=0, in_ready=1.
  - g=000, last=0, zero=1, neg=0, two=0.
- Latency:
  - Group 0 is valid the cycle after in_fire.
  - Without backpressure, a transaction takes NG cycles, with one group per cycle.
- Backpressure: while out_valid & ~out_ready, the values of g, idx, last, neg, two and zero hold stable.
- in_valid while EMIT and not on the last out_fire: x is ignored and not latched. The source must hold it.
- Reset mid-transaction: all groups not yet emitted are discarded. The first cycle after deassertion is IDLE.
- The transaction cannot be aborted other than by reset.

## Structure
- Package booth_pkg:
  - typedef booth_grp_t (logic [2:0]).
  - localparams for the eight group codes (G_ZERO_P=000, G_P1A=001, G_P1B=010, G_P2=011, G_M2=100, G_M1A=101, G_M1B=110, G_ZERO_N=111).
  - This package is shared with the action decoder.
- Sub-module booth_grp_flags: combinational g → {neg, two, zero}. It is reused by the action decoder's select logic.
- The top holds the FSM, the shift register and the index counter.

## Test plan
- Reset with rst pulsed mid-EMIT after group 1 → the next cycle shows out_valid=0, in_ready=1, zero=1. Then x=8'h55 is accepted and the output restarts at idx=0.
- x=8'h7F, out_ready=1 → groups 110, 111, 111, 011 on idx 0..3 in consecutive cycles. last is set only on idx 3. Digits −1,0,0,+2 sum to 127.
- x=8'h80 → 000, 000, 000, 100. On idx 3, neg=1 and two=1 (digit −2·64 = −128).
- x=8'h55 → four groups of 010 (+1 each), summing to 85. Hold out_ready=0 for 3 cycles on idx 1 → g, idx and flags stay stable, and in_ready=0 throughout.
- Back-to-back: x=8'h00 then x=8'hFF with in_valid held → groups 000×4, then 110, 111, 111, 111 with no idle cycle. in_ready=1 only in the cycle of the last out_fire.
- Random: 1000 random x with random out_ready → a scoreboard checks Σ d_i·4^i == $signed(x) for every transaction, and that the flags match booth_pkg.

Source files
------------

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared radix-4 Booth group type, group codes and FSM states
package booth_pkg;

  typedef logic [2:0] booth_grp_t;

  // Group codes {x[2i+1], x[2i], x[2i-1]} and the digit each selects
  localparam booth_grp_t G_ZERO_P = 3'b000;  //  0
  localparam booth_grp_t G_P1A    = 3'b001;  // +1
  localparam booth_grp_t G_P1B    = 3'b010;  // +1
  localparam booth_grp_t G_P2     = 3'b011;  // +2
  localparam booth_grp_t G_M2     = 3'b100;  // -2
  localparam booth_grp_t G_M1A    = 3'b101;  // -1
  localparam booth_grp_t G_M1B    = 3'b110;  // -1
  localparam booth_grp_t G_ZERO_N = 3'b111;  //  0

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } booth_state_t;

endpackage

// File: rtl/booth_group_enc_if.sv
// rtl/booth_group_enc_if.sv - operand-in / Booth-group-out handshake bundle
interface booth_group_enc_if #(
  parameter int W = 8
);
  import booth_pkg::*;

  localparam int NG = W / 2;
  localparam int IW = $clog2(NG);

  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    x;
  logic            out_valid;
  logic            out_ready;
  booth_grp_t      g;
  logic [IW-1:0]   idx;
  logic            last;
  logic            neg;
  logic            two;
  logic            zero;

  // Operand stage / partial-product consumer side
  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, g, idx, last, neg, two, zero
  );

  // Booth recoder side
  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, g, idx, last, neg, two, zero
  );

endinterface

// File: rtl/booth_grp_flags.sv
// rtl/booth_grp_flags.sv - combinational Booth group to {neg, two, zero} action flags
module booth_grp_flags
  import booth_pkg::*;
(
  input  booth_grp_t g,
  output logic       neg,
  output logic       two,
  output logic       zero
);

  // Map each of the eight group codes to its sign/magnitude action
  always_comb begin
    neg  = 1'b0;
    two  = 1'b0;
    zero = 1'b0;
    case (g)
      G_ZERO_P, G_ZERO_N: zero = 1'b1;
      G_P1A, G_P1B:       ;
      G_P2:               two = 1'b1;
      G_M2: begin
        neg = 1'b1;
        two = 1'b1;
      end
      G_M1A, G_M1B:       neg = 1'b1;
      default:            ;
    endcase
  end

endmodule

// File: rtl/booth_group_enc.sv
// rtl/booth_group_enc.sv - sequential radix-4 Booth recoder, one group per handshake
module booth_group_enc
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  booth_group_enc_if.slave bus
);

  localparam int NG = W / 2;
  localparam int IW = $clog2(NG);

  booth_state_t  state;
  logic [W:0]    sr;     // bit 0 is the implicit x[-1]
  logic [IW-1:0] idx;

  logic emit;
  logic last_grp;
  logic out_fire;
  logic in_fire;

  assign emit     = (state == S_EMIT);
  assign last_grp = emit & (idx == IW'(NG - 1));
  assign out_fire = emit & bus.out_ready;
  // Ready again in the cycle the final group leaves, so operands can stream with no bubble
  assign in_fire  = bus.in_valid & bus.in_ready;

  assign bus.in_ready  = ~emit | (out_fire & last_grp);
  assign bus.out_valid = emit;
  assign bus.g         = sr[2:0];
  assign bus.idx       = idx;
  assign bus.last      = last_grp;

  booth_grp_flags u_flags (
    .g    (sr[2:0]),
    .neg  (bus.neg),
    .two  (bus.two),
    .zero (bus.zero)
  );

  // FSM, operand shift register and group index counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      sr    <= '0;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_fire) begin
            sr    <= {bus.x, 1'b0};
            idx   <= '0;
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_fire) begin
            if (last_grp) begin
              if (in_fire) begin
                sr  <= {bus.x, 1'b0};
                idx <= '0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              // Arithmetic shift keeps the sign bit feeding the upper groups
              sr  <= {{2{sr[W]}}, sr[W:2]};
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_group_enc.sv
// tb/tb_booth_group_enc.sv - directed and scoreboard bench for booth_group_enc
module tb_booth_group_enc;
  import booth_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_group_enc_if #(.W(W)) bus ();

  booth_group_enc #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int digit(input logic [2:0] gg);
    case (gg)
      G_ZERO_P, G_ZERO_N: return 0;
      G_P1A, G_P1B:       return 1;
      G_P2:               return 2;
      G_M2:               return -2;
      default:            return -1;
    endcase
  endfunction

  function automatic int exp_flags(input logic [2:0] gg);
    int d;
    d = digit(gg);
    return {29'd0, d < 0, (d == 2) || (d == -2), d == 0};
  endfunction

  function automatic int obs_flags();
    return {29'd0, bus.neg, bus.two, bus.zero};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with out_ready held high; gs = {g3, g2, g1, g0}
  task automatic run_x(input string nm, input logic [7:0] xv, input logic [11:0] gs);
    int sum;
    sum = 0;
    bus.x = xv;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check({nm, "_accept"}, bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check({nm, "_valid"}, bus.out_valid, 1);
      check({nm, "_idx"}, bus.idx, i);
      check({nm, "_g"}, bus.g, gs[3*i +: 3]);
      check({nm, "_last"}, bus.last, (i == 3) ? 1 : 0);
      check({nm, "_flags"}, obs_flags(), exp_flags(gs[3*i +: 3]));
      sum += digit(bus.g) * (1 << (2 * i));
      step();
    end
    check({nm, "_sum"}, sum, $signed(xv));
    check({nm, "_idle"}, bus.out_valid, 0);
  endtask

  initial begin
    int sum;
    int ng;
    int cyc;
    logic [7:0] xr;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_valid", bus.out_valid, 0);
    check("rst_ready", bus.in_ready, 1);
    check("rst_g", bus.g, 0);
    check("rst_idx", bus.idx, 0);
    check("rst_last", bus.last, 0);
    check("rst_flags", obs_flags(), 3'b001);
    step();
    rst = 1'b0;
    #1;

    // Reset in the middle of a transaction
    bus.x = 8'h7F;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    check("mid_idx_before", bus.idx, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    check("mid_rst_zero", bus.zero, 1);
    #2;
    rst = 1'b0;
    step();
    check("mid_post_valid", bus.out_valid, 0);
    bus.x = 8'h55;
    bus.in_valid = 1'b1;
    #1;
    check("mid_accept", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    #1;
    check("mid_restart_idx", bus.idx, 0);
    check("mid_restart_g", bus.g, 3'b010);
    check("mid_restart_valid", bus.out_valid, 1);
    for (int i = 1; i < 4; i++) begin
      step();
      check("mid_drain_idx", bus.idx, i);
    end
    step();
    check("mid_drain_idle", bus.out_valid, 0);

    run_x("x7f", 8'h7F, {3'b011, 3'b111, 3'b111, 3'b110});
    run_x("x80", 8'h80, {3'b100, 3'b000, 3'b000, 3'b000});
    run_x("x55", 8'h55, {3'b010, 3'b010, 3'b010, 3'b010});

    // Backpressure on idx 1 of 0x55
    bus.x = 8'h55;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.x = 8'hAA;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_idx", bus.idx, 1);
      check("bp_g", bus.g, 3'b010);
      check("bp_flags", obs_flags(), 3'b000);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_valid", bus.out_valid, 1);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("bp_resume_idx", bus.idx, 1);
    check("bp_resume_g", bus.g, 3'b010);
    step();
    check("bp_next_idx", bus.idx, 2);
    check("bp_next_g", bus.g, 3'b010);
    step();
    step();
    check("bp_idle", bus.out_valid, 0);

    // Back-to-back 0x00 then 0xFF with in_valid held
    bus.x = 8'h00;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.x = 8'hFF;
      #1;
      check("b2b_a_valid", bus.out_valid, 1);
      check("b2b_a_idx", bus.idx, i);
      check("b2b_a_g", bus.g, 3'b000);
      check("b2b_a_in_ready", bus.in_ready, (i == 3) ? 1 : 0);
      step();
    end
    bus.in_valid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("b2b_b_valid", bus.out_valid, 1);
      check("b2b_b_idx", bus.idx, i);
      check("b2b_b_g", bus.g, (i == 0) ? 3'b110 : 3'b111);
      check("b2b_b_in_ready", bus.in_ready, (i == 3) ? 1 : 0);
      step();
    end
    check("b2b_idle", bus.out_valid, 0);

    // Random operands with random consumer stalls, checked by digit sum
    for (int t = 0; t < 1000; t++) begin
      xr = 8'($urandom_range(0, 255));
      bus.x = xr;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      #1;
      check("rnd_accept", bus.in_ready, 1);
      step();
      bus.in_valid = 1'b0;
      sum = 0;
      ng = 0;
      cyc = 0;
      while (ng < 4 && cyc < 200) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        #1;
        if (bus.out_valid && bus.out_ready) begin
          check("rnd_idx", bus.idx, ng);
          check("rnd_last", bus.last, (ng == 3) ? 1 : 0);
          check("rnd_flags", obs_flags(), exp_flags(bus.g));
          sum += digit(bus.g) * (1 << (2 * ng));
          ng++;
        end
        step();
        cyc++;
      end
      check("rnd_groups", ng, 4);
      check("rnd_sum", sum, $signed(xr));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
